// File: rtl/lsu_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, serialiser states and the divider helper.
package lsu_uart_pkg;

    localparam logic [3:0] UART_TXDATA  = 4'h0;
    localparam logic [3:0] UART_STATUS  = 4'h4;
    localparam logic [3:0] UART_BAUDDIV = 4'h8;

    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_BUSY  = 3;
    localparam int STAT_OVF   = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    // A divider of zero would stall the bit timer, so it runs at one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/lsu_uart_tx_if.sv
// Load/store bus between the core and the UART register window.
// Read data flows back combinationally for same-cycle writeback.
interface lsu_uart_tx_if;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic        i_lsu_wren;
    logic [31:0] o_ld_data;

    modport master (
        output i_lsu_addr,
        output i_st_data,
        output i_lsu_wren,
        input  o_ld_data
    );

    modport slave (
        input  i_lsu_addr,
        input  i_st_data,
        input  i_lsu_wren,
        output o_ld_data
    );
endinterface

// File: rtl/lsu_uart_tx_fifo.sv
// Show-ahead TX FIFO. The head is always visible on o_rdata so the
// serialiser can load it in the same edge that it pops.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rdPtr];

    // Storage array carries no reset; stale entries are never visible past the count.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; simultaneous push and pop keep the count.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lsu_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's load/store path.
// Stores queue bytes without stalling; loads return status in the same cycle.
module lsu_uart_tx
    import lsu_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic         i_clk,
    input  logic         i_reset,
    lsu_uart_tx_if.slave bus,
    output logic         o_uart_tx,
    output logic         o_irq_empty
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            w_hit;
    logic            w_wrTx;
    logic            w_wrStatus;
    logic            w_wrBaud;
    logic            w_fifoPush;
    logic            w_ovfSet;
    logic            w_pop;
    logic            w_bitEnd;
    logic            w_busy;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [7:0]      w_rdata;
    logic            w_unused;

    logic            r_ovf;
    logic [15:0]     r_baudDiv;
    uart_state_e     r_state;
    logic [15:0]     r_timer;
    logic [15:0]     r_divEff;
    logic [2:0]      r_bitIdx;
    logic [7:0]      r_shift;
    logic            r_tx;

    // Upper half of the store word has no destination in this register map.
    assign w_unused = ^bus.i_st_data[31:16];

    assign w_hit      = (bus.i_lsu_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wrTx     = bus.i_lsu_wren && w_hit && (bus.i_lsu_addr[3:0] == UART_TXDATA);
    assign w_wrStatus = bus.i_lsu_wren && w_hit && (bus.i_lsu_addr[3:0] == UART_STATUS);
    assign w_wrBaud   = bus.i_lsu_wren && w_hit && (bus.i_lsu_addr[3:0] == UART_BAUDDIV);

    // Fullness is judged before any same-cycle pop, so a store to a full FIFO is always lost.
    assign w_fifoPush = w_wrTx && !w_full;
    assign w_ovfSet   = w_wrTx && w_full;

    assign w_bitEnd = (r_timer == 16'd0);
    assign w_busy   = (r_state != IDLE);
    assign w_pop    = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bitEnd));

    assign o_uart_tx   = r_tx;
    assign o_irq_empty = (w_count == '0) && !w_busy;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_fifoPush),
        .i_pop   (w_pop),
        .i_wdata (bus.i_st_data[7:0]),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Software-visible registers: sticky overflow flag and the baud divider.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_ovf     <= 1'b0;
            r_baudDiv <= DEFAULT_DIV;
        end else begin
            if (w_ovfSet) begin
                r_ovf <= 1'b1;
            end else if (w_wrStatus && bus.i_st_data[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_wrBaud) begin
                r_baudDiv <= bus.i_st_data[15:0];
            end
        end
    end

    // Serialiser: the divider is latched at each frame start so mid-frame writes wait a frame.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= IDLE;
            r_timer  <= 16'd0;
            r_divEff <= 16'd1;
            r_bitIdx <= 3'd0;
            r_shift  <= 8'd0;
            r_tx     <= 1'b1;
        end else if (w_pop) begin
            r_shift  <= w_rdata;
            r_divEff <= eff_div(r_baudDiv);
            r_timer  <= eff_div(r_baudDiv) - 16'd1;
            r_bitIdx <= 3'd0;
            r_tx     <= 1'b0;
            r_state  <= START;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                end
                START: begin
                    if (w_bitEnd) begin
                        r_tx    <= r_shift[0];
                        r_timer <= r_divEff - 16'd1;
                        r_state <= DATA;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                DATA: begin
                    if (w_bitEnd) begin
                        r_timer <= r_divEff - 16'd1;
                        if (r_bitIdx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx     <= r_shift[1];
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                STOP: begin
                    if (w_bitEnd) begin
                        r_tx    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Load data is decoded straight from the address for same-cycle writeback.
    always_comb begin
        bus.o_ld_data = 32'd0;
        if (w_hit) begin
            case (bus.i_lsu_addr[3:0])
                UART_STATUS:  bus.o_ld_data = {27'd0, r_ovf, w_busy, w_empty, w_full, 1'b0};
                UART_BAUDDIV: bus.o_ld_data = {16'd0, r_baudDiv};
                default:      bus.o_ld_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_uart_tx.sv
// Bench for lsu_uart_tx: a frame-position model (queue of bytes, frame
// offset divided by bit length) is checked every cycle, alongside
// directed stores with hand-computed waveforms and register values.
module tb_lsu_uart_tx;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 8;
    localparam logic [15:0] DEFDIV = 16'd434;

    logic clk;
    logic rst;
    logic uartTx;
    logic irqEmpty;

    lsu_uart_tx_if bus();

    lsu_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (DEFDIV)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .bus         (bus),
        .o_uart_tx   (uartTx),
        .o_irq_empty (irqEmpty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared;
    int nMismatched;
    int cyc;

    // Model state: pending bytes, registers, and the frame in flight.
    logic [7:0]  mq[$];
    logic        mOvf;
    logic [15:0] mBaud;
    logic        mActive;
    logic [7:0]  mByte;
    int          mDiv;
    int          mPos;
    logic        mValid;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic modelLine();
        int seg;
        if (!mActive) return 1'b1;
        seg = mPos / mDiv;
        if (seg == 0) return 1'b0;
        if (seg >= 9) return 1'b1;
        return mByte[seg-1];
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [31:0] off;
        if (a < BASE || a >= BASE + 32'd16) return 32'd0;
        off = a - BASE;
        case (off)
            32'd4:   return {27'd0, mOvf, mActive, (mq.size() == 0), (mq.size() == DEPTH), 1'b0};
            32'd8:   return {16'd0, mBaud};
            default: return 32'd0;
        endcase
    endfunction

    // Model update on every rising edge, using the inputs held during the cycle.
    initial begin
        int  sizePre;
        logic frameEnd;
        logic [31:0] off;
        mValid = 1'b0;
        mActive = 1'b0;
        mDiv = 1;
        mPos = 0;
        mOvf = 1'b0;
        mBaud = DEFDIV;
        mByte = 8'd0;
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                mq.delete();
                mOvf = 1'b0;
                mBaud = DEFDIV;
                mActive = 1'b0;
                mPos = 0;
                mValid = 1'b1;
            end else if (mValid) begin
                sizePre = mq.size();
                frameEnd = mActive && (mPos == 10 * mDiv - 1);
                if (mActive) mPos++;
                if (frameEnd) mActive = 1'b0;
                if (!mActive && sizePre > 0) begin
                    mByte = mq.pop_front();
                    mDiv = (mBaud == 16'd0) ? 1 : int'(mBaud);
                    mPos = 0;
                    mActive = 1'b1;
                end
                if (bus.i_lsu_wren && bus.i_lsu_addr >= BASE && bus.i_lsu_addr < BASE + 32'd16) begin
                    off = bus.i_lsu_addr - BASE;
                    if (off == 32'd0) begin
                        if (sizePre == DEPTH) mOvf = 1'b1;
                        else mq.push_back(bus.i_st_data[7:0]);
                    end else if (off == 32'd4) begin
                        if (bus.i_st_data[4]) mOvf = 1'b0;
                    end else if (off == 32'd8) begin
                        mBaud = bus.i_st_data[15:0];
                    end
                end
            end
        end
    end

    // Every cycle, compare line, interrupt and load data against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (mValid) begin
                checkOutput("cyc_line", {31'd0, uartTx}, {31'd0, modelLine()});
                checkOutput("cyc_irq", {31'd0, irqEmpty}, {31'd0, (mq.size() == 0) && !mActive});
                checkOutput("cyc_ld", bus.o_ld_data, modelRead(bus.i_lsu_addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        bus.i_lsu_addr = addr;
        bus.i_st_data  = data;
        bus.i_lsu_wren = 1'b1;
        tick();
        bus.i_lsu_wren = 1'b0;
        bus.i_st_data  = 32'd0;
    endtask

    task automatic readReg(input logic [31:0] addr, input logic [31:0] expected, input string name);
        bus.i_lsu_addr = addr;
        #1;
        checkOutput(name, bus.o_ld_data, expected);
    endtask

    task automatic watchFrame(input logic [9:0] pat, input int div, input string tag);
        for (int i = 0; i < 10 * div; i++) begin
            tick();
            checkOutput($sformatf("%s_seg%0d", tag, i / div), {31'd0, uartTx}, {31'd0, pat[i / div]});
        end
    endtask

    task automatic waitIdle(input int limit, input string name);
        int g;
        g = 0;
        while (!irqEmpty && g < limit) begin
            tick();
            g++;
        end
        checkOutput(name, {31'd0, irqEmpty}, 32'd1);
    endtask

    initial begin
        int busyCnt;
        int guard;
        int startCyc;
        nCompared = 0;
        nMismatched = 0;
        rst = 1'b0;
        bus.i_lsu_addr = 32'd0;
        bus.i_st_data  = 32'd0;
        bus.i_lsu_wren = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        readReg(BASE + 32'h4, 32'h0000_0004, "rst_status");
        readReg(BASE + 32'h8, 32'd434, "rst_baud");
        checkOutput("rst_line", {31'd0, uartTx}, 32'd1);
        checkOutput("rst_irq", {31'd0, irqEmpty}, 32'd1);

        // 1: single 0x55 frame at 4 clocks per bit
        applyStimulus(BASE + 32'h8, 32'd4);
        applyStimulus(BASE, 32'h55);
        checkOutput("t1_latency", {31'd0, uartTx}, 32'd1);
        watchFrame(10'b1010101010, 4, "t1");
        tick();
        checkOutput("t1_irq_back", {31'd0, irqEmpty}, 32'd1);
        readReg(BASE + 32'h4, 32'h0000_0004, "t1_status_idle");

        // 2: three back-to-back frames; busy seen from the third store's cycle to the end
        applyStimulus(BASE, 32'h01);
        applyStimulus(BASE, 32'h02);
        applyStimulus(BASE, 32'h03);
        bus.i_lsu_addr = BASE + 32'h4;
        #1;
        busyCnt = 0;
        guard = 0;
        while (bus.o_ld_data[3] && guard < 300) begin
            busyCnt++;
            tick();
            guard++;
        end
        checkOutput("t2_busy_cycles", busyCnt, 32'd119);
        waitIdle(50, "t2_idle");

        // 3: overflow while a frame is already on the line
        applyStimulus(BASE, 32'hC3);
        tick();
        tick();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(BASE, 32'h10 + k);
        end
        readReg(BASE + 32'h4, 32'h0000_001A, "t3_status_full_ovf");
        applyStimulus(BASE + 32'h4, 32'h10);
        readReg(BASE + 32'h4, 32'h0000_000A, "t3_status_ovf_clr");
        waitIdle(600, "t3_drain");

        // 4: divider change mid-frame, then divider zero
        applyStimulus(BASE, 32'hA5);
        startCyc = cyc;
        repeat (5) tick();
        applyStimulus(BASE + 32'h8, 32'd8);
        readReg(BASE + 32'h8, 32'd8, "t4_baud8");
        applyStimulus(BASE, 32'h3C);
        waitIdle(300, "t4_idle");
        checkOutput("t4_span", cyc - startCyc, 32'd121);
        applyStimulus(BASE + 32'h8, 32'd0);
        readReg(BASE + 32'h8, 32'd0, "t4_baud0");
        applyStimulus(BASE, 32'hF0);
        watchFrame(10'b1111100000, 1, "t4z");
        tick();
        checkOutput("t4z_irq", {31'd0, irqEmpty}, 32'd1);

        // 5: reset during data bit 3
        applyStimulus(BASE + 32'h8, 32'd4);
        applyStimulus(BASE, 32'h55);
        repeat (18) tick();
        checkOutput("t5_bit3", {31'd0, uartTx}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("t5_line_high", {31'd0, uartTx}, 32'd1);
        rst = 1'b1;
        readReg(BASE + 32'h4, 32'h0000_0004, "t5_status");
        readReg(BASE + 32'h8, 32'd434, "t5_baud");

        // 6: reads around the window and stores outside it
        readReg(BASE, 32'd0, "t6_txdata_rd");
        readReg(BASE + 32'hC, 32'd0, "t6_reserved_rd");
        readReg(32'h2000_0004, 32'd0, "t6_outside_rd");
        readReg(BASE + 32'h14, 32'd0, "t6_above_rd");
        applyStimulus(32'h1001_0018, 32'd8);
        readReg(BASE + 32'h8, 32'd434, "t6_baud_kept");
        applyStimulus(32'h1011_0000, 32'h41);
        applyStimulus(BASE + 32'hC, 32'hFFFF_FFFF);
        repeat (3) tick();
        checkOutput("t6_no_frame", {31'd0, irqEmpty}, 32'd1);
        readReg(BASE + 32'h4, 32'h0000_0004, "t6_status");
        readReg(BASE + 32'hC, 32'd0, "t6_reserved_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Hard stop in case a wait loop is ever defeated.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
